// File: rtl/gesture_pkg.sv
// gesture_pkg: shared definitions for the gesture recognition path.
//   - gesture code constants
//   - 4x4 sensor frame pattern table (also used by gesture_fsm)
//   - emulator state enum
//   - helpers: gesture_valid(), frame_pat()
package gesture_pkg;

    localparam logic [3:0] GEST_NONE    = 4'h0;
    localparam logic [3:0] GEST_SWIPE_R = 4'h1;
    localparam logic [3:0] GEST_SWIPE_L = 4'h2;
    localparam logic [3:0] GEST_TAP     = 4'h3;
    localparam logic [3:0] GEST_HOLD    = 4'h4;

    // Row = gesture code - 1, column = frame index; bit i is sensor i.
    localparam logic [0:3][0:3][3:0] GEST_FRAMES = '{
        '{4'b0001, 4'b0010, 4'b0100, 4'b1000},  // SWIPE_R
        '{4'b1000, 4'b0100, 4'b0010, 4'b0001},  // SWIPE_L
        '{4'b0110, 4'b0000, 4'b0110, 4'b0000},  // TAP
        '{4'b1111, 4'b1111, 4'b1111, 4'b1111}   // HOLD
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } emu_state_t;

    function automatic logic gesture_valid(input logic [3:0] code);
        return (code >= GEST_SWIPE_R) && (code <= GEST_HOLD);
    endfunction

    // Only meaningful for valid codes (1..4).
    function automatic logic [3:0] frame_pat(input logic [3:0] code, input logic [1:0] idx);
        logic [3:0] row;
        row = code - 4'd1;
        return GEST_FRAMES[row[1:0]][idx];
    endfunction

endpackage

// File: rtl/gesture_hold_timer.sv
// gesture_hold_timer: 8-bit loadable down counter, stops at zero.
//   clk, rst     : clock, synchronous active-high reset
//   load, value  : load value (has priority over counting)
//   en           : decrement when nonzero
//   expire       : count is zero (current cycle is the last of the interval)
module gesture_hold_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    input  logic       en,
    output logic       expire
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= 8'd0;
        else if (load)
            count <= value;
        else if (en && count != 8'd0)
            count <= count - 8'd1;
    end

    assign expire = (count == 8'd0);

endmodule

// File: rtl/gesture_sensor_emulator.sv
// gesture_sensor_emulator: plays the four sensor frames of a requested
// gesture code onto a 4-bit mock sensor bus, then an idle gap, then a
// one-cycle done pulse. Inverse of gesture_fsm, for closed-loop testing.
//   clk, rst      : slow clock, synchronous active-high reset
//   start         : request strobe, sampled only in IDLE
//   gesture_code  : requested code, sampled with start
//   repeat_en     : loop back to frame 0 at end of gap (GESTURE_EMU_REPEAT_EN only)
//   sensor_out    : emulated sensor bus (registered)
//   busy          : frames or gap in progress (registered)
//   done          : one-cycle completion pulse (registered)
//   err           : one-cycle pulse for an unsupported code (registered)
// Optional feature macro: GESTURE_EMU_REPEAT_EN
module gesture_sensor_emulator
    import gesture_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] gesture_code,
`ifdef GESTURE_EMU_REPEAT_EN
    input  logic       repeat_en,
`endif
    output logic [3:0] sensor_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_RELOAD  = 8'(GAP_CYCLES - 1);

    emu_state_t state;
    logic [3:0] code;
    logic [1:0] idx;
    logic       expire;
    logic       accept;
    logic       loop_back;
    logic       tmr_load;
    logic [7:0] tmr_value;

    assign accept = (state == ST_IDLE) && start && gesture_valid(gesture_code);

`ifdef GESTURE_EMU_REPEAT_EN
    assign loop_back = (state == ST_GAP) && expire && repeat_en;
`else
    assign loop_back = 1'b0;
`endif

    // Reload on acceptance, every frame boundary, gap entry and loop-back.
    always_comb begin
        tmr_load  = accept || loop_back || ((state == ST_FRAME) && expire);
        tmr_value = ((state == ST_FRAME) && idx == 2'd3) ? GAP_RELOAD : HOLD_RELOAD;
    end

    gesture_hold_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_value),
        .en     (state != ST_IDLE),
        .expire (expire)
    );

    // Outputs are computed for the next state so they stay registered and
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            code       <= GEST_NONE;
            idx        <= 2'd0;
            sensor_out <= 4'b0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_FRAME;
                        code       <= gesture_code;
                        idx        <= 2'd0;
                        sensor_out <= frame_pat(gesture_code, 2'd0);
                        busy       <= 1'b1;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                ST_FRAME: begin
                    if (expire) begin
                        if (idx == 2'd3) begin
                            state      <= ST_GAP;
                            sensor_out <= 4'b0000;
                        end else begin
                            idx        <= idx + 2'd1;
                            sensor_out <= frame_pat(code, idx + 2'd1);
                        end
                    end
                end
                ST_GAP: begin
                    if (loop_back) begin
                        state      <= ST_FRAME;
                        idx        <= 2'd0;
                        sensor_out <= frame_pat(code, 2'd0);
                    end else if (expire) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gesture_sensor_emulator.sv
// Directed bench for gesture_sensor_emulator with H=4, G=8.
module tb_gesture_sensor_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] gesture_code;
    logic       repeat_en;
    logic [3:0] sensor_out;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    // Hand-written frame tables (row: code 1..4 -> 0..3).
    logic [3:0] exp_frames [0:3][0:3] = '{
        '{4'b0001, 4'b0010, 4'b0100, 4'b1000},
        '{4'b1000, 4'b0100, 4'b0010, 4'b0001},
        '{4'b0110, 4'b0000, 4'b0110, 4'b0000},
        '{4'b1111, 4'b1111, 4'b1111, 4'b1111}
    };

    gesture_sensor_emulator #(.HOLD_CYCLES(4), .GAP_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .gesture_code (gesture_code),
`ifdef GESTURE_EMU_REPEAT_EN
        .repeat_en    (repeat_en),
`endif
        .sensor_out   (sensor_out),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check a full request from cycle n+1 to n+25; caller has just applied
    // start at cycle n and stepped once (now at n+1).
    task automatic check_run(input string name, input int row, input int first_c, input int last_c);
        logic [3:0] es;
        logic       eb, ed;
        for (int c = first_c; c <= last_c; c++) begin
            es = (c <= 16) ? exp_frames[row][(c - 1) / 4] : 4'b0000;
            eb = (c <= 24);
            ed = (c == 25);
            checks++;
            if (sensor_out !== es || busy !== eb || done !== ed) begin
                failures++;
                $display("FAIL %s c=%0d got sensor=%b busy=%b done=%b want sensor=%b busy=%b done=%b",
                         name, c, sensor_out, busy, done, es, eb, ed);
            end
            if (c != last_c) step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; gesture_code = 4'h0; repeat_en = 1'b0;
        step(); step();
        checks++;
        if (sensor_out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset got sensor=%b busy=%b done=%b err=%b want all zero",
                     sensor_out, busy, done, err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_swipe_r();
        start = 1'b1; gesture_code = 4'h1;
        step();
        start = 1'b0;
        check_run("swipe_r", 0, 1, 25);
        step();
    endtask

    task automatic test_invalid(input logic [3:0] code);
        start = 1'b1; gesture_code = code;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || sensor_out !== 4'b0000) begin
            failures++;
            $display("FAIL invalid_%h got err=%b busy=%b sensor=%b want err=1 busy=0 sensor=0000",
                     code, err, busy, sensor_out);
        end
        step();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL invalid_%h_after got err=%b busy=%b want 0 0", code, err, busy);
        end
    endtask

    task automatic test_tap_ignore();
        int ndone = 0;
        logic [3:0] es;
        start = 1'b1; gesture_code = 4'h3;
        step();
        for (int c = 1; c <= 30; c++) begin
            // second start at n+5, and code toggling throughout
            start = (c == 5);
            gesture_code = (c == 5) ? 4'h2 : ((c % 2) ? 4'h4 : 4'h1);
            if (done === 1'b1) ndone++;
            if (c <= 16) begin
                es = exp_frames[2][(c - 1) / 4];
                checks++;
                if (sensor_out !== es) begin
                    failures++;
                    $display("FAIL tap_seq c=%0d got %b want %b", c, sensor_out, es);
                end
            end
            step();
        end
        start = 1'b0;
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL tap_done_count got %0d want 1", ndone);
        end
    endtask

    task automatic test_rst_mid();
        start = 1'b1; gesture_code = 4'h4;
        step();                                   // n+1
        start = 1'b0;
        for (int c = 1; c < 6; c++) step();       // n+6
        rst = 1'b1;
        step();                                   // n+7
        rst = 1'b0;
        checks++;
        if (sensor_out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got sensor=%b busy=%b done=%b want 0000 0 0", sensor_out, busy, done);
        end
        step();                                   // n+8
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_idle got busy=%b done=%b want 0 0", busy, done);
        end
        start = 1'b1; gesture_code = 4'h2;
        step();                                   // n+9
        start = 1'b0;
        checks++;
        if (sensor_out !== 4'b1000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_restart got sensor=%b busy=%b want 1000 1", sensor_out, busy);
        end
    endtask

    // Continues the SWIPE_L request left running by test_rst_mid.
    task automatic test_back_to_back();
        int  budget = 40;
        while (done !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_wait_done got done=%b want 1 within budget", done);
        end
        start = 1'b1; gesture_code = 4'h2;
        step();
        start = 1'b0;
        check_run("b2b", 1, 1, 25);
        step();
    endtask

`ifdef GESTURE_EMU_REPEAT_EN
    task automatic test_repeat();
        repeat_en = 1'b1;
        start = 1'b1; gesture_code = 4'h1;
        step();
        start = 1'b0;
        check_run("repeat_first", 0, 1, 24);
        step();                                   // n+25
        checks++;
        if (sensor_out !== 4'b0001 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL repeat_loop got sensor=%b busy=%b done=%b want 0001 1 0", sensor_out, busy, done);
        end
        repeat_en = 1'b0;
        // second pass: frames n+25..n+40, gap n+41..n+48, done n+49
        for (int c = 26; c <= 49; c++) begin
            step();
            if (c == 49) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL repeat_done got done=%b busy=%b want 1 0", done, busy);
                end
            end else if (done !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL repeat_early_done c=%0d got done=1 want 0", c);
            end
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_swipe_r();
        test_invalid(4'h7);
        test_invalid(4'h0);
        test_tap_ignore();
        test_rst_mid();
        test_back_to_back();
`ifdef GESTURE_EMU_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gesture_sensor_emulator.md
# gesture_sensor_emulator

Drives the 4-bit mock sensor bus with the frame sequence belonging to a requested gesture code: the inverse of the gesture FSM, which turns sensor frames into a code. It runs in the slow-clock domain and feeds `gesture_fsm.sensor_in` in place of the board switches, so the whole recognition path can be exercised in closed loop. One request produces four timed sensor frames, then an idle gap, then a completion pulse.

## Interface
- `HOLD_CYCLES`, default 4: clock cycles each sensor frame is held; legal range 1..255.
- `GAP_CYCLES`, default 8: cycles of `4'b0000` driven after the last frame; legal range 1..255.

- `clk`  in  1: single clock (slow clock from the divider).
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request strobe; sampled only in IDLE.
- `gesture_code`  in  4: requested gesture; sampled with `start`.
- `sensor_out`  out  4: emulated sensor bus; reset `4'b0000`.
- `busy`  out  1: high while frames or gap are being driven; reset 0.
- `done`  out  1: one-cycle completion pulse; reset 0.
- `err`  out  1: one-cycle pulse for an unsupported code; reset 0.
- `repeat_en`  in  1: present only with `GESTURE_EMU_REPEAT_EN` (see Configuration).

## Operation
- Gesture frames, where frame0 is driven first and bit i is sensor i:
  - `4'h1` SWIPE_R: 0001, 0010, 0100, 1000.
  - `4'h2` SWIPE_L: 1000, 0100, 0010, 0001.
  - `4'h3` TAP: 0110, 0000, 0110, 0000.
  - `4'h4` HOLD: 1111, 1111, 1111, 1111.
  - Any other code, including `4'h0`, is invalid.
- States:
  - IDLE: `sensor_out`=0000, `busy`=0.
  - IDLE to FRAME on `start` with a valid code. Latch the code, frame index = 0, hold counter = `HOLD_CYCLES`-1.
  - IDLE stays in IDLE on `start` with an invalid code; pulse `err` the next cycle.
  - FRAME: drive the frame for the current index. When the hold counter reaches 0, advance the index and reload the counter. After index 3 expires, go to GAP with counter = `GAP_CYCLES`-1.
  - GAP: drive 0000. On expiry go to IDLE and pulse `done`.
- `start` while `busy` is ignored. The latched code is immune to `gesture_code` changes after acceptance.
- `start` coincident with a `done` cycle is accepted, because the FSM is already in IDLE.
- `rst` at any point, including mid-frame: next cycle is IDLE with all outputs at reset values; the latched code is discarded.
- Counters are 8 bits, down-counting, with no wrap: they reload on every frame and gap entry.

## Timing
- `start` accepted at cycle n.
- `busy`=1 and frame0 on `sensor_out` at n+1, both registered.
- Frame k occupies cycles n+1+k·H through n+(k+1)·H, where H=`HOLD_CYCLES`.
- Gap occupies n+4H+1 through n+4H+G, where G=`GAP_CYCLES`.
- `done`=1 and `busy`=0 at n+4H+G+1.
- Invalid code: `err`=1 at n+1; `busy` and `sensor_out` are unchanged.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `GESTURE_EMU_REPEAT_EN` defined:
  - Adds the `repeat_en` input.
  - If `repeat_en`=1 in the last GAP cycle, return to FRAME index 0 with the same latched code. No `done` pulse is produced and `busy` stays high.
- Not defined:
  - No `repeat_en` port.
  - Every accepted request yields exactly one `done`.

## Structure
- `gesture_pkg` holds:
  - the gesture code constants (`GEST_NONE`, `GEST_SWIPE_R`, `GEST_SWIPE_L`, `GEST_TAP`, `GEST_HOLD`);
  - the 4×4 frame pattern table, shared with `gesture_fsm`;
  - the state enum (IDLE, FRAME, GAP).
- One sub-module, `gesture_hold_timer`: an 8-bit loadable down counter with an `expire` output. It is reused for both hold and gap timing.

## Test plan
- Reset, then `start` with `4'h1`, H=4, G=8: `sensor_out` is 0001/0010/0100/1000 for 4 cycles each from n+1, 0000 for n+17..n+24, `done` at n+25, `busy` high n+1..n+24.
- `start` with `4'h7`, then `4'h0`: `err` pulses at n+1 each time; `sensor_out` stays 0000 and `busy` stays 0.
- `start` with `4'h3`, then a second `start` with `4'h2` at n+5 plus `gesture_code` toggling mid-run: the TAP sequence is unaltered and exactly one `done`.
- `start` with `4'h4`, `rst` at n+6: `sensor_out`=0000 and `busy`=0 at n+7, no `done`; a new `start` with `4'h2` at n+8 yields 1000 at n+9.
- Back-to-back: `start` with `4'h2` asserted in the `done` cycle of a prior request: accepted, frame0=1000 the next cycle.
- With `GESTURE_EMU_REPEAT_EN` and `repeat_en`=1, `4'h1`: frame0 0001 reappears at n+25 with no `done`. Dropping `repeat_en` yields `done` after the following gap.
